// File: rtl/sram_bank_arbiter_pkg.sv
// sram_ctrl_pkg: shared types and helpers for the SRAM bank arbiter.
//   arb_state_e  - transaction FSM states
//   calc_addr_w  - request address width {bank,row,col}
//   addr_bank/addr_row/addr_col - field extraction from a request address
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

    function automatic int calc_addr_w(int nb, int rows, int cols, int dw);
        return $clog2(nb) + $clog2(rows) + $clog2(cols / dw);
    endfunction

    // Bank sits in the MSBs, column in the LSBs.
    function automatic logic [31:0] addr_bank(logic [31:0] a, int row_w, int col_w);
        return a >> (row_w + col_w);
    endfunction

    function automatic logic [31:0] addr_row(logic [31:0] a, int row_w, int col_w);
        return (a >> col_w) & ((32'd1 << row_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_col(logic [31:0] a, int col_w);
        return a & ((32'd1 << col_w) - 32'd1);
    endfunction

endpackage

// File: rtl/sram_bank_arbiter_if.sv
// Requester-side bus of the SRAM bank arbiter.
//   req_valid/req_ready - per-requester handshake, ready is one-hot
//   req_we/addr/wdata/wmask - per-requester payload, requester i at index i
//   rsp_valid - one-cycle completion pulse to the owner
//   rsp_rdata - shared read data, valid with any rsp_valid bit
// Modports: master (client side), slave (arbiter side).
interface sram_bank_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 11
);
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0]                 req_we;
    logic [NUM_REQ-1:0][ADDR_W-1:0]     req_addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wmask;
    logic [NUM_REQ-1:0]                 rsp_valid;
    logic [DATA_WIDTH-1:0]              rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_bank_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin pick among NUM_REQ requests.
//   clk, rst      - clock, async active-low reset
//   req_i         - request vector
//   advance_i     - pulse on handshake; pointer moves past the winner
//   gnt_o         - one-hot grant (zero when no request)
//   gnt_idx_o     - index of the granted requester
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      gnt_idx_o
);
    logic [IW-1:0] ptr_q;
    logic          found;
    int            idx;

    // Scan from the pointer upward with wraparound; first set bit wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!found && req_i[IW'(idx)]) begin
                found            = 1'b1;
                gnt_o[IW'(idx)]  = 1'b1;
                gnt_idx_o        = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else if (advance_i) begin
            ptr_q <= (gnt_idx_o == IW'(NUM_REQ - 1)) ? '0 : gnt_idx_o + 1'b1;
        end
    end
endmodule

// File: rtl/sram_bank_arbiter.sv
// sram_bank_arbiter: shares one banked SRAM array among NUM_REQ requesters.
// One transaction in flight; round-robin arbitration; registered read data.
//   clk, rst  - clock, async active-low reset
//   bus       - requester bus (sram_bank_arbiter_if.slave)
//   mem_*     - array interface; mem_data_out valid the cycle after address
// Optional (SRAM_ARB_PERF_CNT_EN): perf_clr input, perf_grant_cnt output with
// one 16-bit saturating grant counter per requester.
module sram_bank_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int NUM_BANKS  = 4,
    parameter  int ROWS       = 64,
    parameter  int COLS       = 64,
    parameter  int DATA_WIDTH = 8,
    localparam int BW         = $clog2(NUM_BANKS),
    localparam int RW         = $clog2(ROWS),
    localparam int CW         = $clog2(COLS / DATA_WIDTH),
    localparam int ADDR_W     = calc_addr_w(NUM_BANKS, ROWS, COLS, DATA_WIDTH),
    localparam int IW         = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_bank_arbiter_if.slave    bus,
    output logic [BW-1:0]         mem_bank_select,
    output logic [RW-1:0]         mem_row_select,
    output logic [CW-1:0]         mem_col_select,
    output logic [DATA_WIDTH-1:0] mem_write_enable,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
`ifdef SRAM_ARB_PERF_CNT_EN
    ,
    input  logic                     perf_clr,
    output logic [NUM_REQ-1:0][15:0] perf_grant_cnt
`endif
);
    arb_state_e            state_q, state_d;
    logic [NUM_REQ-1:0]    gnt;
    logic [IW-1:0]         gnt_idx;
    logic                  hs;
    logic                  we_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, wmask_q, rdata_q;
    logic [IW-1:0]         owner_q;

    // Ready is gated by rst so nothing is offered while reset is held.
    assign hs            = rst && (state_q == IDLE) && (|bus.req_valid);
    assign bus.req_ready = hs ? gnt : '0;
    assign bus.rsp_rdata = rdata_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (bus.req_valid),
        .advance_i (hs),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs) state_d = ISSUE;
            ISSUE:   state_d = we_q ? RESP : CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            owner_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                we_q    <= bus.req_we[gnt_idx];
                addr_q  <= bus.req_addr[gnt_idx];
                wdata_q <= bus.req_wdata[gnt_idx];
                wmask_q <= bus.req_wmask[gnt_idx];
                owner_q <= gnt_idx;
            end
            if (state_q == CAPTURE) rdata_q <= mem_data_out;
        end
    end

    // Address stays on the array through CAPTURE so the read word is stable;
    // data and strobe only appear in ISSUE.
    always_comb begin
        mem_bank_select  = '0;
        mem_row_select   = '0;
        mem_col_select   = '0;
        mem_write_enable = '0;
        mem_data_in      = '0;
        bus.rsp_valid    = '0;
        if (state_q == ISSUE || state_q == CAPTURE) begin
            mem_bank_select = BW'(addr_bank(32'(addr_q), RW, CW));
            mem_row_select  = RW'(addr_row(32'(addr_q), RW, CW));
            mem_col_select  = CW'(addr_col(32'(addr_q), CW));
        end
        if (state_q == ISSUE) begin
            mem_data_in      = wdata_q;
            mem_write_enable = we_q ? wmask_q : '0;
        end
        if (state_q == RESP) bus.rsp_valid[owner_q] = 1'b1;
    end

`ifdef SRAM_ARB_PERF_CNT_EN
    logic [NUM_REQ-1:0][15:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (perf_clr) begin
            cnt_q <= '0;
        end else if (hs && cnt_q[gnt_idx] != 16'hFFFF) begin
            cnt_q[gnt_idx] <= cnt_q[gnt_idx] + 16'd1;
        end
    end

    assign perf_grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed bench for sram_bank_arbiter with a behavioural SRAM array model.
module tb_sram_bank_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int AW = 11;

    logic clk = 1'b0;
    logic rst;
    logic [1:0]    mem_bank_select;
    logic [5:0]    mem_row_select;
    logic [2:0]    mem_col_select;
    logic [DW-1:0] mem_write_enable;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;
`ifdef SRAM_ARB_PERF_CNT_EN
    logic                perf_clr;
    logic [NR-1:0][15:0] perf_grant_cnt;
`endif

    int n_chk = 0;
    int n_fail = 0;
    bit found;
    logic [NR-1:0] got;

    sram_bank_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

    sram_bank_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .mem_bank_select  (mem_bank_select),
        .mem_row_select   (mem_row_select),
        .mem_col_select   (mem_col_select),
        .mem_write_enable (mem_write_enable),
        .mem_data_in      (mem_data_in),
        .mem_data_out     (mem_data_out)
`ifdef SRAM_ARB_PERF_CNT_EN
        ,
        .perf_clr         (perf_clr),
        .perf_grant_cnt   (perf_grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Array model: per-bit write, registered read of the applied address.
    logic [DW-1:0] mem_arr [0:3][0:63][0:7];
    initial begin
        for (int b = 0; b < 4; b++)
            for (int r = 0; r < 64; r++)
                for (int c = 0; c < 8; c++)
                    mem_arr[b][r][c] = '0;
    end
    always @(posedge clk) begin
        mem_arr[mem_bank_select][mem_row_select][mem_col_select] <=
            (mem_arr[mem_bank_select][mem_row_select][mem_col_select] & ~mem_write_enable) |
            (mem_data_in & mem_write_enable);
        mem_data_out <= mem_arr[mem_bank_select][mem_row_select][mem_col_select];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] mk(input int b, input int r, input int c);
        return {2'(b), 6'(r), 3'(c)};
    endfunction

    // One full transaction from requester r; checks grant, strobe, latency, data.
    task automatic txn(input int r, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] m,
                       input logic [DW-1:0] exp_rd);
        @(posedge clk); #1;
        bus.req_valid        = 4'(1 << r);
        bus.req_we[2'(r)]    = w;
        bus.req_addr[2'(r)]  = a;
        bus.req_wdata[2'(r)] = d;
        bus.req_wmask[2'(r)] = m;
        @(negedge clk);
        chk("grant", 32'(bus.req_ready), 32'(1 << r));
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(negedge clk);
        chk("issue_we", 32'(mem_write_enable), w ? 32'(m) : 32'd0);
        chk("issue_bank", 32'(mem_bank_select), 32'(a[10:9]));
        chk("issue_rsp", 32'(bus.rsp_valid), 32'd0);
        if (w) chk("issue_din", 32'(mem_data_in), 32'(d));
        if (!w) begin
            @(negedge clk);
            chk("cap_rsp", 32'(bus.rsp_valid), 32'd0);
            chk("cap_we", 32'(mem_write_enable), 32'd0);
        end
        @(negedge clk);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(1 << r));
        chk("rsp_we", 32'(mem_write_enable), 32'd0);
        if (!w) chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
    endtask

    initial begin
        rst           = 1'b0;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
`ifdef SRAM_ARB_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        // Reset held with random requests: every output stays zero.
        for (int k = 0; k < 3; k++) begin
            bus.req_valid = 4'($urandom);
            bus.req_we    = 4'($urandom);
            bus.req_wmask = 32'($urandom);
            @(negedge clk);
            chk("rst_ready", 32'(bus.req_ready), 32'd0);
            chk("rst_rsp", 32'(bus.rsp_valid), 32'd0);
            chk("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
            chk("rst_mem", {mem_write_enable, mem_data_in, 5'(mem_bank_select), mem_row_select,
                            mem_col_select}, 32'd0);
        end
        bus.req_valid = 4'b1010;
        bus.req_we    = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_first_grant", 32'(bus.req_ready), 32'b0010);
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (3) @(posedge clk);

        // Single write then read.
        txn(0, 1'b1, mk(2, 5, 3), 8'hA5, 8'hFF, 8'h00);
        txn(0, 1'b0, mk(2, 5, 3), 8'h00, 8'h00, 8'hA5);

        // Partial mask.
        txn(1, 1'b1, mk(1, 10, 2), 8'hFF, 8'hFF, 8'h00);
        txn(2, 1'b1, mk(1, 10, 2), 8'h00, 8'h0F, 8'h00);
        txn(3, 1'b0, mk(1, 10, 2), 8'h00, 8'h00, 8'hF0);

        // Bank isolation.
        for (int b = 0; b < 4; b++) txn(b, 1'b1, mk(b, 7, 1), 8'(8'h11 * (b + 1)), 8'hFF, 8'h00);
        for (int b = 0; b < 4; b++) txn(3 - b, 1'b0, mk(b, 7, 1), 8'h00, 8'h00, 8'(8'h11 * (b + 1)));

        // Reset during CAPTURE drops the read.
        @(posedge clk); #1;
        bus.req_valid       = 4'b0100;
        bus.req_we[2]       = 1'b0;
        bus.req_addr[2]     = mk(2, 5, 3);
        @(negedge clk);
        chk("mid_grant", 32'(bus.req_ready), 32'b0100);
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("mid_we", 32'(mem_write_enable), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_rsp", 32'(bus.rsp_valid), 32'd0);
            chk("post_rst_ready", 32'(bus.req_ready), 32'd0);
        end
        txn(3, 1'b0, mk(2, 5, 3), 8'h00, 8'h00, 8'hA5);

        // Round-robin with all requesters held high; pointer starts at 0.
        for (int i = 0; i < 4; i++) bus.req_addr[2'(i)] = mk(i, 0, 0);
        bus.req_we = '0;
        @(posedge clk); #1;
        bus.req_valid = '1;
        for (int g = 0; g < 12; g++) begin
            found = 1'b0;
            got   = '0;
            for (int c = 0; c < 10 && !found; c++) begin
                @(negedge clk);
                if (bus.req_ready != '0) begin
                    found = 1'b1;
                    got   = bus.req_ready;
                end
            end
            chk("rr_grant", 32'(got), 32'(1 << (g % 4)));
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (4) @(posedge clk);

`ifdef SRAM_ARB_PERF_CNT_EN
        #1;
        perf_clr = 1'b1;
        @(posedge clk); #1;
        perf_clr = 1'b0;
        for (int k = 0; k < 5; k++) txn(1, 1'b1, mk(0, 9, 0), 8'(k), 8'hFF, 8'h00);
        @(negedge clk);
        chk("perf_cnt1", 32'(perf_grant_cnt[1]), 32'd5);
        chk("perf_cnt0", 32'(perf_grant_cnt[0]), 32'd0);
        @(posedge clk); #1;
        perf_clr = 1'b1;
        @(posedge clk); #1;
        perf_clr = 1'b0;
        @(negedge clk);
        chk("perf_clr", 32'(perf_grant_cnt[1]), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
